// File: rtl/uart_rx_oversample_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding and the
// default bit period in clk cycles.
package uart_rx_oversample_pkg;

  // 10 MHz clock / 115200 baud.
  localparam int CLKS_PER_BIT_DEFAULT = 87;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge
// detector on the synchronized value. All flops reset to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Driven only by flops, so rx has no combinational path to the outputs.
  assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with mid-bit sampling, a one-entry valid/ready holding
// register, and single-cycle frame-error and overrun pulses.
module uart_rx_oversample
  import uart_rx_oversample_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_hit;
  logic          load;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    stop_hit = 1'b0;

    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            // A line back high at mid-start was a glitch, not a frame.
            state_d = rx_s ? IDLE : DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              state_d = STOP;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            // Leave mid-stop so the next start edge is never missed.
            state_d  = IDLE;
            cnt_d    = '0;
            stop_hit = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // The holding register accepts a new byte when empty or draining this cycle.
  assign load = stop_hit & rx_s & (~m_valid | m_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data    <= 8'h00;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      m_valid   <= load | (m_valid & ~m_ready);
      frame_err <= stop_hit & ~rx_s;
      overrun   <= stop_hit & rx_s & m_valid & ~m_ready;
      if (load) begin
        m_data <= shift_q;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample at 16 clocks per bit: latency, glitch
// rejection, framing error, overrun, simultaneous drain/load, reset and enable.
module tb_uart_rx_oversample;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       rx = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Event tallies kept by the monitor; tests compare deltas against them.
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         vcyc = 0;
  int         xfer_n = 0;
  logic [7:0] xfer_data [0:63];

  always #5 clk = ~clk;

  uart_rx_oversample #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rx        (rx),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (m_valid) vcyc++;
    if (m_valid && m_ready && rst_n) begin
      if (xfer_n < 64) xfer_data[xfer_n] = m_data;
      xfer_n++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {frame_err, overrun}); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_basic;
    int n;
    bit seen;
    int fe0, ov0, v0, x0;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc; x0 = xfer_n;
    m_ready = 1'b1;
    n = 0;
    seen = 1'b0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (!seen && n < 400) begin
          tick(1);
          n++;
          if (m_valid) seen = 1'b1;
        end
      end
    join
    checks++; if (n !== 155) begin errors++; $display("FAIL basic_latency got=%0d exp=155 edges", n); end
    checks++; if (xfer_n - x0 !== 1) begin errors++; $display("FAIL basic_xfers got=%0d exp=1", xfer_n - x0); end
    checks++; if (xfer_data[x0] !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", xfer_data[x0]); end
    checks++; if (vcyc - v0 !== 1) begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=1", vcyc - v0); end
    checks++; if ((fe_cnt - fe0) + (ov_cnt - ov0) !== 0) begin errors++; $display("FAIL basic_pulses got=%0d exp=0", (fe_cnt - fe0) + (ov_cnt - ov0)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_glitch;
    int fe0, ov0, x0;
    fe0 = fe_cnt; ov0 = ov_cnt; x0 = xfer_n;
    rx = 1'b0;
    tick(4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
    rx = 1'b1;
    tick(30);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop got=%b exp=0", busy); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL glitch_m_valid got=%b exp=0", m_valid); end
    checks++; if ((fe_cnt - fe0) + (ov_cnt - ov0) + (xfer_n - x0) !== 0) begin errors++; $display("FAIL glitch_events got=%0d exp=0", (fe_cnt - fe0) + (ov_cnt - ov0) + (xfer_n - x0)); end
  endtask

  task automatic test_frame_err;
    int fe0, x0;
    fe0 = fe_cnt; x0 = xfer_n;
    m_ready = 1'b1;
    send_byte(8'h3C, 1'b0);
    tick(4);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_pulse got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (m_valid !== 1'b0 || xfer_n != x0) begin errors++; $display("FAIL ferr_no_byte got=%b/%0d exp=0/0", m_valid, xfer_n - x0); end
    tick(100);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_held_low_busy got=%b exp=0", busy); end
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_held_low_pulses got=%0d exp=1", fe_cnt - fe0); end
    rx = 1'b1;
    tick(20);
    send_byte(8'h96, 1'b1);
    tick(4);
    checks++; if (xfer_n - x0 !== 1) begin errors++; $display("FAIL ferr_recover_xfers got=%0d exp=1", xfer_n - x0); end
    checks++; if (xfer_data[x0] !== 8'h96) begin errors++; $display("FAIL ferr_recover_data got=%h exp=96", xfer_data[x0]); end
  endtask

  task automatic test_overrun;
    int ov0, x0;
    ov0 = ov_cnt; x0 = xfer_n;
    m_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(4);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL ovr_m_valid got=%b exp=1", m_valid); end
    checks++; if (m_data !== 8'h11) begin errors++; $display("FAIL ovr_m_data_held got=%h exp=11", m_data); end
    checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt - ov0); end
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    checks++; if (xfer_n - x0 !== 1) begin errors++; $display("FAIL ovr_drain_xfers got=%0d exp=1", xfer_n - x0); end
    checks++; if (xfer_data[x0] !== 8'h11) begin errors++; $display("FAIL ovr_drain_data got=%h exp=11", xfer_data[x0]); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_empty got=%b exp=0", m_valid); end
  endtask

  task automatic test_back_to_back;
    int ov0, x0;
    m_ready = 1'b0;
    send_byte(8'h55, 1'b1);
    tick(2);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h55) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/55", m_valid, m_data); end
    ov0 = ov_cnt; x0 = xfer_n;
    fork
      send_byte(8'h66, 1'b1);
      begin
        tick(154);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
      end
    join
    checks++; if (xfer_n - x0 !== 1) begin errors++; $display("FAIL b2b_xfers got=%0d exp=1", xfer_n - x0); end
    checks++; if (xfer_data[x0] !== 8'h55) begin errors++; $display("FAIL b2b_xfer_data got=%h exp=55", xfer_data[x0]); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_kept got=%b exp=1", m_valid); end
    checks++; if (m_data !== 8'h66) begin errors++; $display("FAIL b2b_new_data got=%h exp=66", m_data); end
    checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL b2b_no_overrun got=%0d exp=0", ov_cnt - ov0); end
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    checks++; if (xfer_data[x0 + 1] !== 8'h66 || xfer_n - x0 !== 2) begin errors++; $display("FAIL b2b_drain got=%h/%0d exp=66/2", xfer_data[x0 + 1], xfer_n - x0); end
  endtask

  task automatic test_reset_mid;
    int fe0, ov0, x0;
    m_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; x0 = xfer_n;
    fork
      send_byte(8'hF0, 1'b1);
      begin
        tick(100);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        tick(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_in_reset got=%b exp=0", busy); end
        rst_n = 1'b1;
      end
    join
    tick(10);
    checks++; if ((fe_cnt - fe0) + (ov_cnt - ov0) + (xfer_n - x0) !== 0) begin errors++; $display("FAIL rstmid_abandon got=%0d exp=0", (fe_cnt - fe0) + (ov_cnt - ov0) + (xfer_n - x0)); end
    send_byte(8'h0F, 1'b1);
    tick(4);
    checks++; if (xfer_n - x0 !== 1) begin errors++; $display("FAIL rstmid_xfers got=%0d exp=1", xfer_n - x0); end
    checks++; if (xfer_data[x0] !== 8'h0F) begin errors++; $display("FAIL rstmid_data got=%h exp=0f", xfer_data[x0]); end
  endtask

  task automatic test_enable;
    int fe0, ov0, x0;
    m_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; x0 = xfer_n;
    fork
      send_byte(8'hC3, 1'b1);
      begin
        tick(60);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ena_busy_before got=%b exp=1", busy); end
        ena = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ena_idle_forced got=%b exp=0", busy); end
      end
    join
    tick(4);
    checks++; if ((fe_cnt - fe0) + (ov_cnt - ov0) + (xfer_n - x0) !== 0) begin errors++; $display("FAIL ena_abandon got=%0d exp=0", (fe_cnt - fe0) + (ov_cnt - ov0) + (xfer_n - x0)); end
    ena = 1'b1;
    tick(10);
    send_byte(8'h5A, 1'b1);
    tick(4);
    checks++; if (xfer_n - x0 !== 1 || xfer_data[x0] !== 8'h5A) begin errors++; $display("FAIL ena_recover got=%0d/%h exp=1/5a", xfer_n - x0, xfer_data[x0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
